uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: DATA_W, default 9, width of received data word.
REQ-002 Parameter: TO_W, default 8, width of character-timeout counter and threshold.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cfg_rx_en  input  1  CSR receiver enable.
REQ-006 cfg_data_bits  input  4  CSR data bits; legal 5..9.
REQ-007 cfg_parity_mode  input  2  CSR parity: 0 none, 1 odd, 2 even, 3 mark.
REQ-008 cfg_stop_bits  input  1  CSR stop bits: 0 one, 1 two.
REQ-009 cfg_timeout  input  TO_W  character-timeout threshold in bit times; 0 disables.
REQ-010 bit_tick  input  1  one-cycle pulse per bit period.
REQ-011 frame_active  input  1  receiver frame in progress.
REQ-012 frame_complete  input  1  receiver one-cycle frame-done pulse.
REQ-013 frame_error  input  1  receiver sticky stop-bit error.
REQ-014 parity_error  input  1  receiver sticky parity error.
REQ-015 rx_data  input  DATA_W  assembled data word, valid with frame_complete.
REQ-016 data_bits  output  4  applied data-bit count to receiver.
REQ-017 parity_mode  output  2  applied parity mode to receiver.
REQ-018 stop_bits  output  1  applied stop-bit count to receiver.
REQ-019 start_gate  output  1  applied enable; receiver ANDs with start detection.
REQ-020 error_clear  output  1  one-cycle pulse clearing receiver error flags.
REQ-021 push_valid  output  1  RX FIFO write request.
REQ-022 push_data  output  DATA_W+2  {parity_error, frame_error, rx_data}.
REQ-023 push_ready  input  1  RX FIFO accepts word.
REQ-024 overrun  output  1  one-cycle pulse: frame dropped.
REQ-025 rx_timeout  output  1  one-cycle pulse: character timeout.

Function
REQ-026 FSM states SHALL be IDLE, RECV, PUSH, CLEAR; reset state IDLE.
REQ-027 IDLE->RECV on frame_active; IDLE or RECV->PUSH on frame_complete, capturing push_data same edge.
REQ-028 PUSH: push_valid=1, push_data stable until push_valid&&push_ready; then ->CLEAR.
REQ-029 CLEAR: error_clear=1 for exactly one cycle, then ->IDLE; error_clear 0 in all other states.
REQ-030 frame_complete in PUSH or CLEAR SHALL drop the frame, pulse overrun next cycle, leave captured word and state unchanged.
REQ-031 Shadow config (data_bits, parity_mode, stop_bits, start_gate) SHALL load from cfg_* every cycle while state==IDLE and frame_active==0; held otherwise, so mid-frame CSR writes take effect after the frame.
REQ-032 cfg_data_bits outside 5..9 SHALL leave shadow data_bits unchanged; other fields still load.
REQ-033 Timeout: armed on each accepted push; TO_W-bit counter increments on bit_tick while armed, state IDLE, frame_active 0; saturates.
REQ-034 Counter SHALL clear on frame_active or new push; when counter reaches cfg_timeout!=0, pulse rx_timeout one cycle, disarm, clear counter.
REQ-035 Latency: frame_complete to push_valid 1 cycle; push handshake to error_clear 1 cycle.
REQ-036 Simultaneous frame_complete and push handshake in PUSH: counts as overrun.

Reset
REQ-037 On rst_n low, asynchronously: state IDLE, push_valid/error_clear/overrun/rx_timeout 0, push_data 0, data_bits 8, parity_mode 0, stop_bits 0, start_gate 0, counter 0, disarmed.
REQ-038 Reset mid-PUSH SHALL discard the pending word with no error_clear.

Structure
REQ-039 State enum, parity-mode encodings, and data-bit limits (5, 9, reset 8) SHALL live in shared package uart_rx_pkg.
REQ-040 Timeout counter SHALL be sub-module uart_rx_timeout_cnt; all else flat.

Verification
REQ-041 rx_data=0x0A5, frame_complete, errors 0, push_ready 1 -> push_data=0x0A5 next cycle, error_clear one cycle later.
REQ-042 push_ready held 0 for 20 cycles, second frame_complete -> overrun pulse, push_data still first word, one push on ready.
REQ-043 cfg_data_bits 8->7 while frame_active -> data_bits stays 8 until IDLE and frame_active 0, then 7; cfg_data_bits=12 -> stays 7.
REQ-044 frame_error=1 at frame_complete -> push_data[DATA_W]=1, error_clear pulse after handshake.
REQ-045 cfg_timeout=4, push accepted, 4 bit_ticks idle -> single rx_timeout; cfg_timeout=0 -> none.
REQ-046 rst_n asserted during PUSH -> all outputs to reset values immediately, no push completes.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller.
//   state_t      : controller FSM states
//   parity_t     : parity-mode encodings driven to the receiver
//   DB_MIN/MAX   : legal data-bit range, DB_RST is the post-reset value
//   db_legal()   : true when a requested data-bit count is in range
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_PUSH  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2,
        PAR_MARK = 2'd3
    } parity_t;

    localparam logic [3:0] DB_MIN = 4'd5;
    localparam logic [3:0] DB_MAX = 4'd9;
    localparam logic [3:0] DB_RST = 4'd8;

    function automatic logic db_legal(input logic [3:0] bits);
        return (bits >= DB_MIN) && (bits <= DB_MAX);
    endfunction

endpackage

// File: rtl/uart_rx_timeout_cnt.sv
// Character-timeout counter.
//   i_arm     : accepted push; arms the timer and restarts the count
//   i_clr     : frame in progress; restarts the count
//   i_idle    : controller idle with no frame active; gates counting
//   i_tick    : bit-period pulse
//   i_thresh  : timeout in bit times, 0 disables
//   o_timeout : one-cycle pulse when the count reaches i_thresh
module uart_rx_timeout_cnt #(
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_arm,
    input  logic            i_clr,
    input  logic            i_idle,
    input  logic            i_tick,
    input  logic [TO_W-1:0] i_thresh,
    output logic            o_timeout
);

    logic [TO_W-1:0] r_cnt;
    logic            r_armed;
    logic            r_timeout;
    logic            w_hit;

    assign w_hit     = r_armed && (i_thresh != '0) && (r_cnt == i_thresh);
    assign o_timeout = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_armed   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            // A fresh push always re-arms, even on the cycle a timeout fires.
            if (i_arm) begin
                r_armed <= 1'b1;
                r_cnt   <= '0;
            end else if (w_hit) begin
                r_armed   <= 1'b0;
                r_cnt     <= '0;
                r_timeout <= 1'b1;
            end else if (i_clr) begin
                r_cnt <= '0;
            end else if (r_armed && i_idle && i_tick && (r_cnt != '1)) begin
                r_cnt <= r_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: shadows CSR config into the receiver between
// frames, captures finished frames into the RX FIFO with a valid/ready
// handshake, clears receiver error flags after each push, flags overruns
// and raises a character timeout.
//   cfg_*            : CSR configuration inputs
//   bit_tick         : bit-period pulse (timeout counting)
//   frame_*, *_error : receiver status, rx_data valid with frame_complete
//   data_bits..      : shadowed config applied to the receiver
//   start_gate
//   error_clear      : one-cycle pulse after each accepted push
//   push_*           : RX FIFO write port, push_data = {perr, ferr, data}
//   overrun          : pulse, a frame arrived while a word was still pending
//   rx_timeout       : pulse, idle line for cfg_timeout bit times after a push
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int TO_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_rx_en,
    input  logic [3:0]        cfg_data_bits,
    input  logic [1:0]        cfg_parity_mode,
    input  logic              cfg_stop_bits,
    input  logic [TO_W-1:0]   cfg_timeout,
    input  logic              bit_tick,
    input  logic              frame_active,
    input  logic              frame_complete,
    input  logic              frame_error,
    input  logic              parity_error,
    input  logic [DATA_W-1:0] rx_data,
    output logic [3:0]        data_bits,
    output logic [1:0]        parity_mode,
    output logic              stop_bits,
    output logic              start_gate,
    output logic              error_clear,
    output logic              push_valid,
    output logic [DATA_W+1:0] push_data,
    input  logic              push_ready,
    output logic              overrun,
    output logic              rx_timeout
);

    state_t              r_state, w_state_nxt;
    logic                w_capture;
    logic                w_push_valid;
    logic                w_error_clear;
    logic                w_drop;
    logic                w_cfg_load;
    logic [DATA_W+1:0]   r_push_data;
    logic                r_overrun;
    logic [3:0]          r_data_bits;
    logic [1:0]          r_parity_mode;
    logic                r_stop_bits;
    logic                r_start_gate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_push_valid  = 1'b0;
        w_error_clear = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A frame may finish without us ever seeing frame_active.
                if (frame_complete) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_PUSH;
                end else if (frame_active) begin
                    w_state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (frame_complete) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_PUSH;
                end else if (!frame_active) begin
                    // Aborted frame (e.g. false start): go back to idle.
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PUSH: begin
                w_push_valid = 1'b1;
                if (push_ready) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_error_clear = 1'b1;
                w_state_nxt   = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Frames finishing while a word is pending or errors are being cleared
    // are lost; the captured word and the handshake proceed untouched.
    assign w_drop     = frame_complete && ((r_state == ST_PUSH) || (r_state == ST_CLEAR));
    assign w_cfg_load = (r_state == ST_IDLE) && !frame_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push_data   <= '0;
            r_overrun     <= 1'b0;
            r_data_bits   <= DB_RST;
            r_parity_mode <= PAR_NONE;
            r_stop_bits   <= 1'b0;
            r_start_gate  <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_capture)
                r_push_data <= {parity_error, frame_error, rx_data};
            if (w_cfg_load) begin
                if (db_legal(cfg_data_bits))
                    r_data_bits <= cfg_data_bits;
                r_parity_mode <= cfg_parity_mode;
                r_stop_bits   <= cfg_stop_bits;
                r_start_gate  <= cfg_rx_en;
            end
        end
    end

    uart_rx_timeout_cnt #(.TO_W(TO_W)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_arm     (w_push_valid && push_ready),
        .i_clr     (frame_active),
        .i_idle    (w_cfg_load),
        .i_tick    (bit_tick),
        .i_thresh  (cfg_timeout),
        .o_timeout (rx_timeout)
    );

    assign push_valid  = w_push_valid;
    assign error_clear = w_error_clear;
    assign push_data   = r_push_data;
    assign overrun     = r_overrun;
    assign data_bits   = r_data_bits;
    assign parity_mode = r_parity_mode;
    assign stop_bits   = r_stop_bits;
    assign start_gate  = r_start_gate;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int DATA_W = 9;
    localparam int TO_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_rx_en;
    logic [3:0]        cfg_data_bits;
    logic [1:0]        cfg_parity_mode;
    logic              cfg_stop_bits;
    logic [TO_W-1:0]   cfg_timeout;
    logic              bit_tick;
    logic              frame_active;
    logic              frame_complete;
    logic              frame_error;
    logic              parity_error;
    logic [DATA_W-1:0] rx_data;
    logic [3:0]        data_bits;
    logic [1:0]        parity_mode;
    logic              stop_bits;
    logic              start_gate;
    logic              error_clear;
    logic              push_valid;
    logic [DATA_W+1:0] push_data;
    logic              push_ready;
    logic              overrun;
    logic              rx_timeout;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(.DATA_W(DATA_W), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_rx_en(cfg_rx_en), .cfg_data_bits(cfg_data_bits),
        .cfg_parity_mode(cfg_parity_mode), .cfg_stop_bits(cfg_stop_bits),
        .cfg_timeout(cfg_timeout), .bit_tick(bit_tick),
        .frame_active(frame_active), .frame_complete(frame_complete),
        .frame_error(frame_error), .parity_error(parity_error),
        .rx_data(rx_data), .data_bits(data_bits), .parity_mode(parity_mode),
        .stop_bits(stop_bits), .start_gate(start_gate),
        .error_clear(error_clear), .push_valid(push_valid),
        .push_data(push_data), .push_ready(push_ready),
        .overrun(overrun), .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_rx_en = 1'b1; cfg_data_bits = 4'd6; cfg_parity_mode = 2'd2;
        cfg_stop_bits = 1'b1; cfg_timeout = '0; bit_tick = 1'b0;
        frame_active = 1'b0; frame_complete = 1'b0; frame_error = 1'b0;
        parity_error = 1'b0; rx_data = '0; push_ready = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({push_valid, error_clear, overrun, rx_timeout, start_gate, stop_bits} !== 6'b0 ||
            push_data !== '0 || data_bits !== 4'd8 || parity_mode !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got pv=%b ec=%b ov=%b to=%b sg=%b sb=%b pd=%h db=%0d pm=%0d want all 0, db=8",
                     push_valid, error_clear, overrun, rx_timeout, start_gate, stop_bits,
                     push_data, data_bits, parity_mode);
        end
        rst_n = 1'b1;
        cfg_data_bits = 4'd8; cfg_parity_mode = 2'd0; cfg_stop_bits = 1'b0;
        cyc(); cyc();
        checks++;
        if (data_bits !== 4'd8 || start_gate !== 1'b1 || push_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got db=%0d sg=%b pv=%b want 8 1 0", data_bits, start_gate, push_valid);
        end
    endtask

    // Sends one frame_complete pulse with the given word.
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic fe, input logic pe);
        rx_data = d; frame_error = fe; parity_error = pe; frame_complete = 1'b1;
        cyc();
        frame_complete = 1'b0; frame_error = 1'b0; parity_error = 1'b0;
    endtask

    task automatic test_basic_push();
        push_ready = 1'b1;
        send_frame(9'h0A5, 1'b0, 1'b0);
        checks++;
        if (push_valid !== 1'b1 || push_data !== 11'h0A5) begin
            errors++;
            $display("FAIL basic_push got pv=%b pd=%h want 1 0a5", push_valid, push_data);
        end
        checks++;
        if (error_clear !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_clear got ec=%b want 0", error_clear);
        end
        cyc();
        checks++;
        if (error_clear !== 1'b1 || push_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear got ec=%b pv=%b want 1 0", error_clear, push_valid);
        end
        cyc();
        checks++;
        if (error_clear !== 1'b0) begin
            errors++;
            $display("FAIL basic_clear_len got ec=%b want 0", error_clear);
        end
    endtask

    task automatic test_backpressure();
        int ovr = 0;
        int pushes = 0;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        a = 9'($urandom);
        b = ~a;
        push_ready = 1'b0;
        send_frame(a, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 7) begin
                rx_data = b; frame_complete = 1'b1;
            end
            cyc();
            frame_complete = 1'b0;
            if (i == 7) begin
                checks++;
                if (overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_overrun_pulse got %b want 1", overrun);
                end
            end
            if (overrun) ovr++;
            if (push_valid !== 1'b1 || push_data !== {2'b00, a}) begin
                checks++; errors++;
                $display("FAIL bp_hold cycle %0d got pv=%b pd=%h want 1 %h", i, push_valid, push_data, {2'b00, a});
            end
        end
        checks++;
        if (ovr != 1) begin
            errors++;
            $display("FAIL bp_overrun_count got %0d want 1", ovr);
        end
        push_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (push_valid && push_ready) begin
                pushes++;
                if (push_data !== {2'b00, a}) begin
                    checks++; errors++;
                    $display("FAIL bp_push_data got %h want %h", push_data, {2'b00, a});
                end
            end
            cyc();
        end
        checks++;
        if (pushes != 1) begin
            errors++;
            $display("FAIL bp_push_count got %0d want 1", pushes);
        end
    endtask

    task automatic test_cfg_shadow();
        cfg_data_bits = 4'd8; cfg_parity_mode = 2'd0; cfg_stop_bits = 1'b0;
        cyc(); cyc();
        frame_active = 1'b1;
        cyc();
        cfg_data_bits = 4'd7; cfg_parity_mode = 2'd1; cfg_stop_bits = 1'b1;
        repeat (5) cyc();
        checks++;
        if (data_bits !== 4'd8 || parity_mode !== 2'd0 || stop_bits !== 1'b0) begin
            errors++;
            $display("FAIL cfg_held got db=%0d pm=%0d sb=%b want 8 0 0", data_bits, parity_mode, stop_bits);
        end
        frame_active = 1'b0;
        repeat (4) cyc();
        checks++;
        if (data_bits !== 4'd7 || parity_mode !== 2'd1 || stop_bits !== 1'b1) begin
            errors++;
            $display("FAIL cfg_applied got db=%0d pm=%0d sb=%b want 7 1 1", data_bits, parity_mode, stop_bits);
        end
        cfg_data_bits = 4'd12; cfg_parity_mode = 2'd3; cfg_rx_en = 1'b0;
        repeat (3) cyc();
        checks++;
        if (data_bits !== 4'd7 || parity_mode !== 2'd3 || start_gate !== 1'b0) begin
            errors++;
            $display("FAIL cfg_illegal got db=%0d pm=%0d sg=%b want 7 3 0", data_bits, parity_mode, start_gate);
        end
        cfg_data_bits = 4'd5; cfg_rx_en = 1'b1;
        repeat (2) cyc();
        checks++;
        if (data_bits !== 4'd5 || start_gate !== 1'b1) begin
            errors++;
            $display("FAIL cfg_min got db=%0d sg=%b want 5 1", data_bits, start_gate);
        end
        cfg_data_bits = 4'd4;
        repeat (2) cyc();
        checks++;
        if (data_bits !== 4'd5) begin
            errors++;
            $display("FAIL cfg_below_min got db=%0d want 5", data_bits);
        end
        cfg_data_bits = 4'd9;
        repeat (2) cyc();
        checks++;
        if (data_bits !== 4'd9) begin
            errors++;
            $display("FAIL cfg_max got db=%0d want 9", data_bits);
        end
        cfg_data_bits = 4'd8; cfg_parity_mode = 2'd0; cfg_stop_bits = 1'b0;
        cyc();
    endtask

    task automatic test_frame_error();
        logic [DATA_W-1:0] d;
        d = 9'($urandom);
        push_ready = 1'b1;
        send_frame(d, 1'b1, 1'b0);
        checks++;
        if (push_valid !== 1'b1 || push_data !== {2'b01, d}) begin
            errors++;
            $display("FAIL ferr_push got pv=%b pd=%h want 1 %h", push_valid, push_data, {2'b01, d});
        end
        cyc();
        checks++;
        if (error_clear !== 1'b1) begin
            errors++;
            $display("FAIL ferr_clear got %b want 1", error_clear);
        end
        cyc();
        send_frame(d, 1'b0, 1'b1);
        checks++;
        if (push_data !== {2'b10, d}) begin
            errors++;
            $display("FAIL perr_push got %h want %h", push_data, {2'b10, d});
        end
        cyc(); cyc();
    endtask

    // Pulses bit_tick n times (one tick every other cycle) counting timeouts.
    task automatic ticks(input int n, inout int seen);
        for (int i = 0; i < n; i++) begin
            bit_tick = 1'b1;
            cyc();
            if (rx_timeout) seen++;
            bit_tick = 1'b0;
            cyc();
            if (rx_timeout) seen++;
        end
    endtask

    task automatic test_timeout();
        int seen = 0;
        cfg_timeout = 8'd4;
        push_ready = 1'b1;
        send_frame(9'h011, 1'b0, 1'b0);
        cyc(); cyc();
        ticks(3, seen);
        repeat (4) begin cyc(); if (rx_timeout) seen++; end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL to_early got %0d pulses want 0", seen);
        end
        ticks(1, seen);
        repeat (4) begin cyc(); if (rx_timeout) seen++; end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL to_fire got %0d pulses want 1", seen);
        end
        ticks(10, seen);
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL to_single got %0d pulses want 1", seen);
        end
        seen = 0;
        cfg_timeout = '0;
        send_frame(9'h022, 1'b0, 1'b0);
        cyc(); cyc();
        ticks(12, seen);
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL to_disabled got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_reset_mid_push();
        int pushes = 0;
        int clears = 0;
        push_ready = 1'b0;
        send_frame(9'h1C3, 1'b1, 1'b1);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (push_valid !== 1'b0 || push_data !== '0 || error_clear !== 1'b0 ||
            data_bits !== 4'd8 || start_gate !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_push got pv=%b pd=%h ec=%b db=%0d sg=%b ov=%b want 0 000 0 8 0 0",
                     push_valid, push_data, error_clear, data_bits, start_gate, overrun);
        end
        cyc();
        rst_n = 1'b1;
        push_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (push_valid) pushes++;
            if (error_clear) clears++;
            cyc();
        end
        checks++;
        if (pushes != 0 || clears != 0) begin
            errors++;
            $display("FAIL rst_discard got pushes=%0d clears=%0d want 0 0", pushes, clears);
        end
    endtask

    // Random frames and back-pressure against an occupancy model: a word is
    // pending from its capture until the FIFO takes it, followed by one
    // error-clear cycle; any frame finishing in that window is lost.
    task automatic test_random();
        logic              pend_m = 1'b0;
        logic              clr_m = 1'b0;
        logic              exp_ovr = 1'b0;
        logic [DATA_W+1:0] word_m = '0;
        logic              fc;
        logic              rdy;
        logic [DATA_W+1:0] w;
        int                nacc = 0;
        for (int i = 0; i < 400; i++) begin
            fc  = ($urandom_range(0, 3) == 0) && (i < 380);
            rdy = ($urandom_range(0, 2) != 0) || (i >= 380);
            w   = 11'($urandom);
            frame_complete = fc; push_ready = rdy;
            {parity_error, frame_error, rx_data} = w;
            if (push_valid !== pend_m || (pend_m && push_data !== word_m)) begin
                checks++; errors++;
                $display("FAIL rnd_push cycle %0d got pv=%b pd=%h want pv=%b pd=%h",
                         i, push_valid, push_data, pend_m, word_m);
            end else checks++;
            if (overrun !== exp_ovr || error_clear !== clr_m) begin
                checks++; errors++;
                $display("FAIL rnd_flags cycle %0d got ov=%b ec=%b want ov=%b ec=%b",
                         i, overrun, error_clear, exp_ovr, clr_m);
            end else checks++;
            exp_ovr = fc && (pend_m || clr_m);
            if (clr_m) clr_m = 1'b0;
            else if (pend_m) begin
                if (rdy) begin pend_m = 1'b0; clr_m = 1'b1; nacc++; end
            end else if (fc) begin
                pend_m = 1'b1; word_m = w;
            end
            cyc();
        end
        frame_complete = 1'b0; frame_error = 1'b0; parity_error = 1'b0;
        checks++;
        if (nacc == 0) begin
            errors++;
            $display("FAIL rnd_activity got %0d accepted want >0", nacc);
        end
        cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_basic_push();
        test_backpressure();
        test_cfg_shadow();
        test_frame_error();
        test_timeout();
        test_random();
        test_reset_mid_push();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
